// File: rtl/pc_next_unit.sv
// pc_next_unit: owns the architectural PC and picks the next fetch address.
// Three-phase loop: BOOT after reset, FETCH (request held until IFU accepts),
// WAIT (until the in-flight instruction commits and supplies its next PC).
module pc_next_unit #(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [XLEN-1:0] MISALIGN_VEC = 32'h8000_0004,
  parameter int unsigned    ALIGN_CHECK  = 1,
  parameter int unsigned    CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             commit_valid,
  input  logic             br_taken,
  input  logic [XLEN-1:0]  pc_imm_sum,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  fetch_pc,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_WAIT
  } state_t;

  state_t           state_q;
  logic             fetch_valid_q;
  logic [XLEN-1:0]  fetch_pc_q;
  logic             misalign_err_q;
  logic [CNT_W-1:0] redirect_cnt_q;

  // Next-PC candidates for the committing instruction.
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  jalr_tgt;
  logic [XLEN-1:0]  taken_tgt;
  logic             taken;
  logic [XLEN-1:0]  next_pc_d;
  logic             misalign_d;
  logic             redirect_d;

  // Sequential path wraps modulo 2^XLEN; JALR target always has bit 0 cleared.
  assign seq_pc   = fetch_pc_q + XLEN'(4);
  assign jalr_tgt = alu_result & ~XLEN'(1);

  // Decode the committing instruction into a next PC, misalign flag and redirect flag.
  always_comb begin
    taken      = 1'b0;
    taken_tgt  = seq_pc;
    next_pc_d  = seq_pc;
    misalign_d = 1'b0;
    redirect_d = 1'b0;
    case (opcode)
      OP_JAL: begin
        taken     = 1'b1;
        taken_tgt = pc_imm_sum;
      end
      OP_JALR: begin
        taken     = 1'b1;
        taken_tgt = jalr_tgt;
      end
      OP_BRANCH: begin
        taken     = br_taken;
        taken_tgt = pc_imm_sum;
      end
      default: begin
        taken     = 1'b0;
        taken_tgt = seq_pc;
      end
    endcase
    if (trap_valid) begin
      // Trap/mret vectors are trusted: no alignment check.
      next_pc_d  = trap_target;
      redirect_d = 1'b1;
    end else if (taken) begin
      redirect_d = 1'b1;
      if ((ALIGN_CHECK != 0) && (taken_tgt[1:0] != 2'b00)) begin
        next_pc_d  = MISALIGN_VEC;
        misalign_d = 1'b1;
      end else begin
        next_pc_d  = taken_tgt;
      end
    end
  end

  // Fetch/commit FSM with registered outputs; commit inputs only matter in S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_BOOT;
      fetch_valid_q  <= 1'b0;
      fetch_pc_q     <= RESET_VECTOR;
      misalign_err_q <= 1'b0;
      redirect_cnt_q <= '0;
    end else begin
      misalign_err_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q       <= S_FETCH;
          fetch_valid_q <= 1'b1;
        end
        S_FETCH: begin
          if (fetch_valid_q && fetch_ready) begin
            state_q       <= S_WAIT;
            fetch_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (commit_valid) begin
            state_q        <= S_FETCH;
            fetch_valid_q  <= 1'b1;
            fetch_pc_q     <= next_pc_d;
            misalign_err_q <= misalign_d;
            if (redirect_d) begin
              redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q       <= S_BOOT;
          fetch_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_valid  = fetch_valid_q;
  assign fetch_pc     = fetch_pc_q;
  assign misalign_err = misalign_err_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Testbench for pc_next_unit: directed scenarios plus randomized instruction
// stream checked against an arithmetic next-PC reference model.
module tb_pc_next_unit;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] MISALIGN_VEC = 32'h8000_0004;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_ADDI   = 7'b0010011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        commit_valid;
  logic        br_taken;
  logic [31:0] pc_imm_sum;
  logic [31:0] alu_result;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic        misalign_err;
  logic [15:0] redirect_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference state: the PC the core should be fetching and the redirect tally.
  logic [31:0] m_pc;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  pc_next_unit dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .commit_valid (commit_valid),
    .br_taken     (br_taken),
    .pc_imm_sum   (pc_imm_sum),
    .alu_result   (alu_result),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_pc     (fetch_pc),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule from the instruction semantics.
  function automatic void model_next(input logic [6:0] op, input logic br,
                                     input logic [31:0] sum, input logic [31:0] alu,
                                     input logic trap, input logic [31:0] tt,
                                     input logic [31:0] pc,
                                     output logic [31:0] nxt, output logic mis,
                                     output logic redir);
    longint unsigned tgt;
    bit is_taken;
    is_taken = 1'b0;
    tgt      = 0;
    mis      = 1'b0;
    redir    = 1'b0;
    if (op == OP_JAL) begin
      is_taken = 1'b1; tgt = sum;
    end else if (op == OP_JALR) begin
      is_taken = 1'b1; tgt = (alu / 2) * 2;
    end else if (op == OP_BRANCH && br) begin
      is_taken = 1'b1; tgt = sum;
    end
    if (trap) begin
      nxt = tt; redir = 1'b1;
    end else if (is_taken) begin
      redir = 1'b1;
      if (tgt % 4 != 0) begin
        nxt = MISALIGN_VEC; mis = 1'b1;
      end else begin
        nxt = 32'(tgt);
      end
    end else begin
      nxt = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
    end
  endfunction

  // Commit one instruction from S_WAIT after 'idle' quiet cycles; checks the result one cycle later.
  task automatic do_commit(input string name, input int idle, input logic [6:0] op,
                           input logic br, input logic [31:0] sum, input logic [31:0] alu,
                           input logic trap, input logic [31:0] tt);
    logic [31:0] e_pc;
    logic e_mis, e_redir;
    for (int i = 0; i < idle; i++) begin
      opcode = 7'($urandom); br_taken = 1'($urandom); trap_valid = 1'($urandom);
      commit_valid = 1'b0;
      tick();
      checks++;
      if (fetch_valid !== 1'b0 || fetch_pc !== m_pc) begin
        failures++;
        $display("FAIL %s_idle: valid=%0b pc=%h required valid=0 pc=%h", name, fetch_valid, fetch_pc, m_pc);
      end
    end
    model_next(op, br, sum, alu, trap, tt, m_pc, e_pc, e_mis, e_redir);
    opcode = op; br_taken = br; pc_imm_sum = sum; alu_result = alu;
    trap_valid = trap; trap_target = tt; commit_valid = 1'b1;
    tick();
    commit_valid = 1'b0; trap_valid = 1'b0;
    m_pc = e_pc;
    if (e_redir) m_cnt = m_cnt + 16'd1;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== m_pc || misalign_err !== e_mis || redirect_cnt !== m_cnt) begin
      failures++;
      $display("FAIL %s: valid=%0b pc=%h err=%0b cnt=%0d required valid=1 pc=%h err=%0b cnt=%0d",
               name, fetch_valid, fetch_pc, misalign_err, redirect_cnt, m_pc, e_mis, m_cnt);
    end
  endtask

  // Hold the request 'stall' cycles with junk commit inputs, then complete the handshake.
  task automatic handshake(input string name, input int stall);
    for (int i = 0; i < stall; i++) begin
      fetch_ready = 1'b0;
      commit_valid = 1'($urandom); trap_valid = 1'($urandom); opcode = OP_JAL;
      pc_imm_sum = $urandom; trap_target = $urandom;
      tick();
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== m_pc || redirect_cnt !== m_cnt || misalign_err !== 1'b0) begin
        failures++;
        $display("FAIL %s_stall: valid=%0b pc=%h cnt=%0d err=%0b required valid=1 pc=%h cnt=%0d err=0",
                 name, fetch_valid, fetch_pc, redirect_cnt, misalign_err, m_pc, m_cnt);
      end
    end
    fetch_ready = 1'b1;
    tick();
    fetch_ready = 1'b0; commit_valid = 1'b0; trap_valid = 1'b0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== m_pc || misalign_err !== 1'b0 || redirect_cnt !== m_cnt) begin
      failures++;
      $display("FAIL %s_accept: valid=%0b pc=%h err=%0b cnt=%0d required valid=0 pc=%h err=0 cnt=%0d",
               name, fetch_valid, fetch_pc, misalign_err, redirect_cnt, m_pc, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_ready = 1'b1; commit_valid = 1'b0; trap_valid = 1'b0;
    opcode = OP_ADDI; br_taken = 1'b0; pc_imm_sum = '0; alu_result = '0; trap_target = '0;
    repeat (3) tick();
    m_pc = RESET_VECTOR; m_cnt = 16'd0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== RESET_VECTOR || misalign_err !== 1'b0 || redirect_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b pc=%h err=%0b cnt=%0d required 0 %h 0 0",
               fetch_valid, fetch_pc, misalign_err, redirect_cnt, RESET_VECTOR);
    end
    rst = 1'b0;
    tick();
    fetch_ready = 1'b0;
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== RESET_VECTOR) begin
      failures++;
      $display("FAIL boot_fetch: valid=%0b pc=%h required valid=1 pc=%h", fetch_valid, fetch_pc, RESET_VECTOR);
    end
  endtask

  task automatic test_stall();
    handshake("stall5", 5);
  endtask

  task automatic test_directed();
    do_commit("addi", 0, OP_ADDI, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    checks++;
    if (fetch_pc !== 32'h8000_0004 || redirect_cnt !== 16'd0) begin
      failures++;
      $display("FAIL addi_abs: pc=%h cnt=%0d required pc=80000004 cnt=0", fetch_pc, redirect_cnt);
    end
    handshake("addi", 0);
    do_commit("jal", 2, OP_JAL, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 32'h0);
    checks++;
    if (fetch_pc !== 32'h8000_0100 || redirect_cnt !== 16'd1) begin
      failures++;
      $display("FAIL jal_abs: pc=%h cnt=%0d required pc=80000100 cnt=1", fetch_pc, redirect_cnt);
    end
    handshake("jal", 1);
    do_commit("jalr_mis", 0, OP_JALR, 1'b0, 32'h0, 32'h8000_0203, 1'b0, 32'h0);
    checks++;
    if (fetch_pc !== 32'h8000_0004 || misalign_err !== 1'b1 || redirect_cnt !== 16'd2) begin
      failures++;
      $display("FAIL jalr_mis_abs: pc=%h err=%0b cnt=%0d required pc=80000004 err=1 cnt=2",
               fetch_pc, misalign_err, redirect_cnt);
    end
    handshake("jalr_mis", 0);
    do_commit("jalr_ok", 0, OP_JALR, 1'b0, 32'h0, 32'h8000_0301, 1'b0, 32'h0);
    handshake("jalr_ok", 0);
    do_commit("trap_top", 1, OP_ADDI, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    handshake("trap_top", 0);
    do_commit("br_wrap", 0, OP_BRANCH, 1'b0, 32'h1234_0000, 32'h0, 1'b0, 32'h0);
    checks++;
    if (fetch_pc !== 32'h0000_0000) begin
      failures++;
      $display("FAIL br_wrap_abs: pc=%h required pc=00000000", fetch_pc);
    end
    handshake("br_wrap", 0);
    do_commit("br_taken", 0, OP_BRANCH, 1'b1, 32'h0000_0040, 32'h0, 1'b0, 32'h0);
    handshake("br_taken", 0);
    do_commit("trap_jal", 0, OP_JAL, 1'b0, 32'h8000_0100, 32'h0, 1'b1, 32'h1234_5679);
    checks++;
    if (fetch_pc !== 32'h1234_5679 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL trap_jal_abs: pc=%h err=%0b required pc=12345679 err=0", fetch_pc, misalign_err);
    end
    handshake("trap_jal", 0);
  endtask

  task automatic test_reset_in_wait();
    opcode = OP_JAL; pc_imm_sum = 32'h4000_0000; commit_valid = 1'b1; rst = 1'b1;
    tick();
    commit_valid = 1'b0;
    m_pc = RESET_VECTOR; m_cnt = 16'd0;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== RESET_VECTOR || redirect_cnt !== 16'd0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_wait: valid=%0b pc=%h cnt=%0d err=%0b required 0 %h 0 0",
               fetch_valid, fetch_pc, redirect_cnt, misalign_err, RESET_VECTOR);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== RESET_VECTOR) begin
      failures++;
      $display("FAIL reset_refetch: valid=%0b pc=%h required valid=1 pc=%h", fetch_valid, fetch_pc, RESET_VECTOR);
    end
    handshake("post_reset", 2);
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    ops[0] = OP_JAL; ops[1] = OP_JALR; ops[2] = OP_BRANCH;
    ops[3] = OP_ADDI; ops[4] = OP_LUI; ops[5] = OP_AUIPC;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] sum;
      sum = $urandom & 32'hFFFF_FFFE;
      do_commit("rand", $urandom_range(0, 3), ops[$urandom_range(0, 5)], 1'($urandom),
                sum, $urandom, ($urandom_range(0, 7) == 0), $urandom);
      handshake("rand", $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_directed();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
